// File: rtl/onehot_grant_decoder.sv
// Turns an encoded index (plus a None flag) into a one-hot grant held for HOLD cycles,
// followed by a GAP-cycle guard before the next code is accepted.
module onehot_grant_decoder #(
  parameter int unsigned N_OUT = 8,
  parameter int unsigned IDX_W = 3,
  parameter int unsigned HOLD  = 2,
  parameter int unsigned GAP   = 1,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] I,
  input  logic             None,
  output logic [N_OUT-1:0] O,
  output logic             O_valid,
  output logic             none_seen,
  output logic             err,
  output logic [CNT_W-1:0] grant_cnt
);

  localparam int unsigned HG_MAX = (HOLD > GAP) ? HOLD : GAP;
  localparam int unsigned TMR_W  = (HG_MAX > 1) ? $clog2(HG_MAX) : 1;

  localparam logic [TMR_W-1:0] HOLD_LD = TMR_W'(HOLD - 1);
  localparam logic [TMR_W-1:0] GAP_LD  = TMR_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [IDX_W:0]   N_OUT_L = (IDX_W+1)'(N_OUT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [N_OUT-1:0] o_q, o_d;
  logic             ov_q, ov_d;
  logic             none_q, none_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] gcnt_q, gcnt_d;
  logic             idx_bad;

  assign idx_bad = {1'b0, I} >= N_OUT_L;

  // Ready comes from registered state only; held low while reset is asserted.
  assign in_ready  = (state_q == S_IDLE) & ~rst;
  assign O         = o_q;
  assign O_valid   = ov_q;
  assign none_seen = none_q;
  assign err       = err_q;
  assign grant_cnt = gcnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      o_q     <= '0;
      ov_q    <= 1'b0;
      none_q  <= 1'b0;
      err_q   <= 1'b0;
      gcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      o_q     <= o_d;
      ov_q    <= ov_d;
      none_q  <= none_d;
      err_q   <= err_d;
      gcnt_q  <= gcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    o_d     = o_q;
    ov_d    = ov_q;
    none_d  = 1'b0;
    err_d   = 1'b0;
    gcnt_d  = gcnt_q;

    case (state_q)
      S_IDLE: begin
        // None takes priority over the index, so an out-of-range I is ignored then.
        if (in_valid) begin
          if (None) begin
            none_d = 1'b1;
          end else if (idx_bad) begin
            err_d = 1'b1;
          end else begin
            o_d     = N_OUT'(1) << I;
            ov_d    = 1'b1;
            tmr_d   = HOLD_LD;
            state_d = S_DRIVE;
          end
        end
      end
      S_DRIVE: begin
        if (tmr_q == '0) begin
          o_d  = '0;
          ov_d = 1'b0;
          if (~&gcnt_q) gcnt_d = gcnt_q + 1'b1;
          if (GAP > 0) begin
            tmr_d   = GAP_LD;
            state_d = S_GAP;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      S_GAP: begin
        if (tmr_q == '0) state_d = S_IDLE;
        else             tmr_d   = tmr_q - 1'b1;
      end
      default: begin
        o_d     = '0;
        ov_d    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_onehot_grant_decoder.sv
// Scoreboard bench: the driver predicts each accepted code's response, a negedge monitor checks it.
module tb_onehot_grant_decoder;

  localparam int unsigned N_OUT   = 6;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned HOLD    = 2;
  localparam int unsigned GAP     = 1;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  localparam logic [1:0] K_GRANT = 2'd0;
  localparam logic [1:0] K_NONE  = 2'd1;
  localparam logic [1:0] K_ERR   = 2'd2;

  typedef struct packed {
    logic [1:0]       kind;
    logic [N_OUT-1:0] val;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IDX_W-1:0] I = '0;
  logic             None = 1'b0;
  logic [N_OUT-1:0] O;
  logic             O_valid;
  logic             none_seen;
  logic             err;
  logic [CNT_W-1:0] grant_cnt;

  onehot_grant_decoder #(
    .N_OUT(N_OUT), .IDX_W(IDX_W), .HOLD(HOLD), .GAP(GAP), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .I(I), .None(None), .O(O), .O_valid(O_valid),
    .none_seen(none_seen), .err(err), .grant_cnt(grant_cnt)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   next_ok = 0;
  exp_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, got, expv, $time);
    end
  endfunction

  // Monitor state: the grant currently expected on O and the expected completed-grant count.
  logic [N_OUT-1:0] act_val = '0;
  bit               act_on = 0;
  int               act_left = 0;
  int               exp_cnt = 0;
  logic [N_OUT-1:0] m_o;
  logic             m_none, m_err;
  exp_t             e;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      act_on = 0;
      act_left = 0;
      exp_cnt = 0;
      chk("ready_in_reset", 32'(in_ready), 32'd0);
      chk("o_in_reset", 32'(O), 32'd0);
      chk("cnt_in_reset", 32'(grant_cnt), 32'd0);
    end else begin
      m_o = '0;
      m_none = 1'b0;
      m_err = 1'b0;
      if (act_on && act_left == 0) begin
        act_on = 0;
        if (exp_cnt < int'(CNT_MAX)) exp_cnt++;
      end
      if (act_on) begin
        m_o = act_val;
        act_left--;
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        case (e.kind)
          K_NONE:  m_none = 1'b1;
          K_ERR:   m_err  = 1'b1;
          default: begin
            m_o = e.val;
            act_val = e.val;
            act_on = 1;
            act_left = int'(HOLD) - 1;
          end
        endcase
      end
      chk("O", 32'(O), 32'(m_o));
      chk("O_valid", 32'(O_valid), 32'(m_o != '0));
      chk("onehot", 32'($countones(O) <= 1), 32'd1);
      chk("none_seen", 32'(none_seen), 32'(m_none));
      chk("err", 32'(err), 32'(m_err));
      chk("grant_cnt", 32'(grant_cnt), 32'(exp_cnt));
      chk("in_ready", 32'(in_ready), 32'(cyc + 1 >= next_ok));
    end
  end

  // Present one code and hold it until the DUT takes it; predict the response at the transfer edge.
  task automatic send(input bit nn, input int idx);
    bit done = 0;
    bit r;
    int k;
    exp_t x;
    @(negedge clk);
    in_valid = 1'b1;
    None = nn;
    I = IDX_W'(idx);
    for (int w = 0; w < 20 && !done; w++) begin
      if (w > 0) @(negedge clk);
      r = in_ready;
      k = cyc + 1;
      @(posedge clk);
      if (r) begin
        done = 1;
        if (nn) begin
          x.kind = K_NONE; x.val = '0;
        end else if (idx >= int'(N_OUT)) begin
          x.kind = K_ERR; x.val = '0;
        end else begin
          x.kind = K_GRANT; x.val = N_OUT'(2 ** idx);
          next_ok = k + int'(HOLD + GAP + 1);
        end
        exp_q.push_back(x);
      end
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: in_ready never high for idx %0d at t=%0t", idx, $time);
    end
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    next_ok = 0;
    idle(2);

    // Single grant, then a back-to-back pair with valid held high.
    send(0, 5);
    idle(6);
    send(0, 5);
    send(0, 0);
    idle(6);

    // Consecutive None codes with an out-of-range-irrelevant I, then error codes.
    send(1, 3);
    send(1, 3);
    send(1, 7);
    send(0, 6);
    send(0, 7);
    send(0, 2);
    idle(6);

    for (int t = 0; t < 200; t++) begin
      send($urandom_range(0, 3) == 0, int'($urandom_range(0, 7)));
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(6);

    // Asynchronous reset in the middle of the second DRIVE cycle.
    send(0, 4);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_O", 32'(O), 32'd0);
    chk("async_rst_O_valid", 32'(O_valid), 32'd0);
    chk("async_rst_cnt", 32'(grant_cnt), 32'd0);
    chk("async_rst_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    next_ok = 0;
    idle(4);

    // Saturate the grant counter.
    for (int t = 0; t < 300; t++) send(0, int'($urandom_range(0, N_OUT - 1)));
    idle(8);
    chk("final_cnt_saturated", 32'(grant_cnt), 32'(CNT_MAX));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish at t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
